// File: rtl/fifo_flags.sv
// Single-clock synchronous FIFO with occupancy count, full/empty and programmable
// almost-full/almost-empty flags, registered-read or first-word-fall-through output.
module fifo_flags #(
  parameter int DATA_W = 8,
  parameter int L      = 8,
  parameter int FWFT   = 0,
  parameter int AF_TH  = L - 1,
  parameter int AE_TH  = 1,
  localparam int ADD_W = $clog2(L),
  localparam int CNT_W = $clog2(L + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADD_W-1:0] PTR_LAST = ADD_W'(L - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_TH);

  logic [DATA_W-1:0] mem [L];
  logic [ADD_W-1:0]  wr_ptr;
  logic [ADD_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_acc;
  logic              rd_acc;

  function automatic logic [ADD_W-1:0] ptr_next(input logic [ADD_W-1:0] p);
    // L need not be a power of two, so wrap by compare rather than overflow
    return (p == PTR_LAST) ? '0 : p + ADD_W'(1);
  endfunction

  assign full         = (cnt == CNT_FULL);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= CNT_AF);
  assign almost_empty = (cnt <= CNT_AE);
  assign count        = cnt;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Storage is deliberately not reset; dout never exposes an unwritten word.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero while empty so reset clears dout at once.
      assign dout     = empty ? '0 : mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              rd_valid_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q     <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) begin
            dout_q <= mem[rd_ptr];
          end
        end
      end

      assign dout     = dout_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule
